ring_osc_freq_meter: RTL and testbench

Digital frequency meter that consumes the free-running output of the three-stage CMOS ring oscillator (`out1`) and reports how many oscillator rising edges occur inside a fixed gate window of system-clock cycles. The meter sits directly downstream of the oscillator. It synchronizes the asynchronous oscillator signal into the clock domain, counts edges under a small FSM, and presents a registered result with a one-cycle valid strobe to the lab readout logic.

---
 rtl/ring_osc_freq_meter.sv | 107 ++++++++++
 tb/tb_ring_osc_freq_meter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ring_osc_freq_meter.sv
// Ring-oscillator frequency meter: synchronizes osc_in and counts its rising
// edges over a fixed gate window of clk cycles, reporting a saturating count.
module ring_osc_freq_meter #(
  parameter int unsigned GATE_CYCLES = 1000,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_in,
  input  logic             start,
  input  logic             continuous,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int unsigned TMR_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_MEASURE,
    S_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   rise_c;
  logic [CNT_W-1:0]       edge_cnt, edge_cnt_nxt;
  logic                   ovf_flag, ovf_flag_nxt;
  logic [TMR_W-1:0]       gate_tmr, gate_tmr_nxt;

  // Synchronizer chain plus history flop for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], osc_in};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign rise_c = sync[SYNC_STAGES-1] & ~prev;

  // Next-state and window datapath
  always_comb begin
    state_nxt    = state;
    edge_cnt_nxt = edge_cnt;
    ovf_flag_nxt = ovf_flag;
    gate_tmr_nxt = gate_tmr;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_ARM;
      end
      S_ARM: begin
        edge_cnt_nxt = '0;
        ovf_flag_nxt = 1'b0;
        gate_tmr_nxt = '0;
        state_nxt    = S_MEASURE;
      end
      S_MEASURE: begin
        gate_tmr_nxt = gate_tmr + TMR_W'(1);
        if (rise_c) begin
          if (edge_cnt == '1) ovf_flag_nxt = 1'b1;
          else                edge_cnt_nxt = edge_cnt + CNT_W'(1);
        end
        // The last cycle's edge is still counted before leaving
        if (gate_tmr == TMR_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = continuous ? S_ARM : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, window registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      edge_cnt <= '0;
      ovf_flag <= 1'b0;
      gate_tmr <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      edge_cnt <= edge_cnt_nxt;
      ovf_flag <= ovf_flag_nxt;
      gate_tmr <= gate_tmr_nxt;
      busy     <= (state_nxt != S_IDLE);
      valid    <= (state_nxt == S_DONE);
      if (state == S_MEASURE && state_nxt == S_DONE) begin
        count    <= edge_cnt_nxt;
        overflow <= ovf_flag_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Bench for ring_osc_freq_meter: short-window and overflow-window instances
// share one oscillator source; results are checked via an expectation queue.
module tb_ring_osc_freq_meter;

  localparam int unsigned GA = 100;
  localparam int unsigned GB = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       osc = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       continuous = 1'b0;
  logic       busy_a, valid_a, overflow_a;
  logic       busy_b, valid_b, overflow_b;
  logic [7:0] count_a, count_b;

  int osc_half  = 0;
  bit osc_level = 1'b0;
  int errors    = 0;
  int checks    = 0;

  typedef struct {
    int lo;
    int hi;
    bit ovf;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    int half;
    bit level;
    int lo;
    int hi;
    bit ovf;
  } vec_t;
  vec_t tbl[5];

  ring_osc_freq_meter #(.GATE_CYCLES(GA), .CNT_W(8), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .osc_in(osc), .start(start_a), .continuous(continuous),
    .busy(busy_a), .valid(valid_a), .count(count_a), .overflow(overflow_a)
  );

  ring_osc_freq_meter #(.GATE_CYCLES(GB), .CNT_W(8), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .osc_in(osc), .start(start_b), .continuous(continuous),
    .busy(busy_b), .valid(valid_b), .count(count_b), .overflow(overflow_b)
  );

  always #5 clk = ~clk;

  // Oscillator model: toggles every osc_half clk periods, offset from clk edges
  initial begin
    int cnt;
    cnt = 0;
    #3;
    forever begin
      #10;
      if (osc_half == 0) begin
        osc = osc_level;
        cnt = 0;
      end else begin
        cnt++;
        if (cnt >= osc_half) begin
          osc = ~osc;
          cnt = 0;
        end
      end
    end
  end

  function automatic bit v_of(input bit sel);
    return sel ? valid_b : valid_a;
  endfunction
  function automatic bit b_of(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction
  function automatic int c_of(input bit sel);
    return sel ? int'(count_b) : int'(count_a);
  endfunction
  function automatic bit o_of(input bit sel);
    return sel ? overflow_b : overflow_a;
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic set_osc(input int half, input bit level);
    osc_half  = half;
    osc_level = level;
    repeat (20) @(negedge clk);
  endtask

  // One single-shot measurement; cycle 1 is the cycle right after the start sample
  task automatic measure(input bit sel, input int g, input int lo, input int hi, input bit ovf);
    exp_t e;
    int   cyc;
    bit   seen;
    e.lo = lo; e.hi = hi; e.ovf = ovf;
    sbq.push_back(e);
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    seen = 1'b0;
    cyc  = -1;
    for (int i = 1; i <= g + 10 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) check("busy_rise", int'(b_of(sel)), 1);
      if (v_of(sel)) begin
        seen = 1'b1;
        cyc  = i;
      end
    end
    check("valid_cycle", cyc, g + 2);
    e = sbq.pop_front();
    if (seen) begin
      check_rng("count", c_of(sel), e.lo, e.hi);
      check("overflow", int'(o_of(sel)), int'(e.ovf));
      @(negedge clk);
      check("valid_width", int'(v_of(sel)), 0);
      check("busy_fall", int'(b_of(sel)), 0);
    end
  endtask

  initial begin
    int nv;
    int nvalid;
    exp_t e;

    tbl[0] = '{half: 5, level: 1'b0, lo: 9,  hi: 11, ovf: 1'b0};
    tbl[1] = '{half: 0, level: 1'b0, lo: 0,  hi: 0,  ovf: 1'b0};
    tbl[2] = '{half: 0, level: 1'b1, lo: 0,  hi: 0,  ovf: 1'b0};
    tbl[3] = '{half: 2, level: 1'b0, lo: 24, hi: 26, ovf: 1'b0};
    tbl[4] = '{half: 1, level: 1'b0, lo: 49, hi: 51, ovf: 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",  int'(busy_a), 0);
    check("rst_valid", int'(valid_a), 0);
    check("rst_count", int'(count_a), 0);
    check("rst_ovf",   int'(overflow_a), 0);
    check("rst_busy_b", int'(busy_b), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven single measurements on the short window
    for (int k = 0; k < 5; k++) begin
      set_osc(tbl[k].half, tbl[k].level);
      measure(1'b0, GA, tbl[k].lo, tbl[k].hi, tbl[k].ovf);
    end

    // Saturation window then normal window on the long-gate instance
    set_osc(1, 1'b0);
    measure(1'b1, GB, 255, 255, 1'b1);
    set_osc(5, 1'b0);
    measure(1'b1, GB, 99, 101, 1'b0);

    // Continuous mode with an ignored mid-window start, then drop continuous
    set_osc(2, 1'b0);
    continuous = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e.lo = 24; e.hi = 26; e.ovf = 1'b0;
      sbq.push_back(e);
    end
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    nv = 0;
    for (int i = 1; i <= 4 * (GA + 2) && nv < 3; i++) begin
      @(negedge clk);
      start_a = (i == GA + 2 + 30);
      if (nv >= 2) continuous = 1'b0;
      if (valid_a) begin
        nv++;
        check("cont_period", i, nv * (GA + 2));
        e = sbq.pop_front();
        check_rng("cont_count", int'(count_a), e.lo, e.hi);
        check("cont_ovf", int'(overflow_a), int'(e.ovf));
      end
    end
    start_a = 1'b0;
    continuous = 1'b0;
    check("cont_windows", nv, 3);
    @(negedge clk);
    check("cont_busy_fall", int'(busy_a), 0);
    check("cont_valid_width", int'(valid_a), 0);
    sbq.delete();

    // Asynchronous reset in the middle of a window
    set_osc(5, 1'b0);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (51) @(negedge clk);
    check("pre_rst_busy", int'(busy_a), 1);
    #1;
    rst = 1'b1;
    #1;
    check("arst_busy",  int'(busy_a), 0);
    check("arst_valid", int'(valid_a), 0);
    check("arst_count", int'(count_a), 0);
    check("arst_ovf",   int'(overflow_a), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nvalid = 0;
    for (int i = 0; i < GA + 50; i++) begin
      @(negedge clk);
      if (valid_a) nvalid++;
    end
    check("no_valid_after_abort", nvalid, 0);
    measure(1'b0, GA, 9, 11, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
